xfer_seq_ctrl: RTL

XFER_SEQ_CTRL -- requirements
Module: xfer_seq_ctrl

---
 rtl/xfer_seq_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xfer_seq_ctrl.sv
// Load/gap/transfer sequencer: drives memory A write strobes, then pairs of memory B
// write/increment strobes, with abort and zero-length error reporting.
module xfer_seq_ctrl #(
  parameter int LEN_W   = 5,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] load_len,
  output logic             wea,
  output logic             inca,
  output logic             web,
  output logic             incb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       phase
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    GAP  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] GAP_LAST = (LEN_W+1)'(GAP_CYC - 1);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W:0]   cnt_reg, cnt_next;
  logic             err_next;
  logic [1:0]       phase_next;
  logic [LEN_W:0]   load_last, xfer_last;

  // One extra counter bit lets XFER count to 2*len-1 at the maximum length
  assign load_last = {1'b0, len_reg} - CNT_ONE;
  assign xfer_last = {len_reg, 1'b0} - CNT_ONE;

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (load_len == '0) begin
            err_next = 1'b1;
          end else begin
            state_next = LOAD;
            len_next   = load_len;
            cnt_next   = '0;
          end
        end
      end
      LOAD: begin
        if (cnt_reg == load_last) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = XFER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      XFER: begin
        if (cnt_reg == xfer_last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides any transition, including the final XFER cycle
    if (state_reg != IDLE && abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      err_next   = 1'b1;
    end
  end

  always_comb begin
    phase_next = 2'b00;
    case (state_next)
      LOAD:    phase_next = 2'b01;
      GAP:     phase_next = 2'b10;
      XFER:    phase_next = 2'b11;
      default: phase_next = 2'b00;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wea       <= 1'b0;
      inca      <= 1'b0;
      web       <= 1'b0;
      incb      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      phase     <= 2'b00;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      wea       <= (state_next == LOAD);
      inca      <= (state_next == LOAD);
      web       <= (state_next == XFER) && !cnt_next[0];
      incb      <= (state_next == XFER) && cnt_next[0];
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      err       <= err_next;
      phase     <= phase_next;
    end
  end

endmodule
